// File: rtl/tri_bus_arb_pkg.sv
// Shared types and helpers for the tri-state bus arbiter slice.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   state_t    bus-owner FSM states (IDLE, DRIVE, TURN)
//   RR_MAX_CH  widest request vector rr_pick can search
//   rr_pick    first set request at/after a pointer, wrapping; -1 if none
package tri_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int RR_MAX_CH = 32;

  // Walk the offsets from the top down so that the last hit written is the
  // smallest offset from ptr, i.e. the round-robin winner.
  function automatic int rr_pick(input logic [RR_MAX_CH-1:0] req,
                                 input int ptr,
                                 input int nch);
    int c;
    rr_pick = -1;
    for (int k = RR_MAX_CH-1; k >= 0; k--) begin
      c = ptr + k;
      if (c >= nch) c = c - nch;
      if ((k < nch) && req[c[4:0]]) rr_pick = c;
    end
  endfunction

endpackage

// File: rtl/tri_bus_arb_rr_arbiter.sv
// Round-robin request picker for the tri-state bus arbiter.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
//
// Ports:
//   req   in   NCH      request vector
//   ptr   in   PW       channel with highest priority this cycle
//   pick  out  NCH      one-hot winner (0 when no request)
//   idx   out  PW       winner index (0 when no request)
//   any   out  1        at least one request present
module rr_arbiter
  import tri_bus_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] pick,
  output logic [PW-1:0]  idx,
  output logic           any
);

  logic [RR_MAX_CH-1:0] req_ext;
  int                   win;

  always_comb begin
    req_ext          = '0;
    req_ext[NCH-1:0] = req;
    win              = rr_pick(req_ext, int'(ptr), NCH);
    any              = (win >= 0);
    idx              = any ? PW'(win) : '0;
    pick             = any ? (NCH'(1) << idx) : '0;
  end

endmodule

// File: rtl/tri_bus_arb.sv
// Round-robin owner of a shared tri-state bus with a Z turnaround between owners.
// Latency: req in cycle n (bus idle) -> gnt/bus driven in cycle n+1; rvalid the cycle after a beat.
// Backpressure: requesters hold req until granted; gnt follows req[owner] combinationally.
//
// Ports:
//   clk         in     1          rising-edge clock
//   rst         in     1          synchronous active-high reset
//   req         in     NCH        per-channel request
//   wdata       in     NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   gnt         out    NCH        one-hot; beat accepted where gnt[i] && req[i]
//   bus         inout  WIDTH      driven by the owner during a beat, else Z
//   rdata       out    WIDTH      bus value captured at the last accepted beat
//   rvalid      out    1          pulse the cycle after each accepted beat
//   contention  out    1          sticky mismatch flag (TRI_BUS_CONTENTION_CHECK_EN), else 0
//
// Build option: define TRI_BUS_CONTENTION_CHECK_EN to compare the bus against the
// owner's data on every accepted beat.
module tri_bus_arb
  import tri_bus_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NCH        = 4,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*WIDTH-1:0] wdata,
  output logic [NCH-1:0]       gnt,
  inout  wire  [WIDTH-1:0]     bus,
  output logic [WIDTH-1:0]     rdata,
  output logic                 rvalid,
  output logic                 contention
);

  localparam int PW = $clog2(NCH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  state_t           state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [NCH-1:0]   owner_oh_q, owner_oh_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [TW-1:0]    turn_q, turn_d;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  logic [WIDTH-1:0] wd_arr [NCH];
  logic [WIDTH-1:0] owner_dat;
  logic             owner_req;
  logic             accept;
  logic [PW-1:0]    owner_nxt;
  logic [PW-1:0]    arb_ptr;
  logic [NCH-1:0]   arb_pick;
  logic [PW-1:0]    arb_idx;
  logic             arb_any;
  logic             grab;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign wd_arr[i] = wdata[i*WIDTH +: WIDTH];
  end

  assign owner_dat = wd_arr[owner_q];
  assign owner_req = req[owner_q];
  assign accept    = (state_q == DRIVE) && owner_req;
  assign owner_nxt = (owner_q == PW'(NCH-1)) ? '0 : owner_q + PW'(1);

  // With no turnaround the next owner is picked in the same cycle the current
  // one leaves, so the search must already start past the departing owner.
  assign arb_ptr = (state_q == DRIVE) ? owner_nxt : ptr_q;

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_rr (
    .req  (req),
    .ptr  (arb_ptr),
    .pick (arb_pick),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign gnt    = accept ? owner_oh_q : '0;
  assign bus    = accept ? owner_dat : {WIDTH{1'bz}};
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    ptr_d      = ptr_q;
    beat_d     = beat_q;
    turn_d     = turn_q;
    grab       = 1'b0;

    case (state_q)
      IDLE: grab = 1'b1;

      DRIVE: begin
        if (accept) beat_d = beat_q + BW'(1);
        // Leave when the owner lets go, or right after its last allowed beat.
        if (!owner_req || (beat_q == BW'(MAX_BURST-1))) begin
          ptr_d = owner_nxt;
          if (TURNAROUND == 0) begin
            grab = 1'b1;
          end else begin
            state_d = TURN;
            turn_d  = '0;
          end
        end
      end

      TURN: begin
        if (turn_q == TW'(TURNAROUND-1)) grab = 1'b1;
        else                             turn_d = turn_q + TW'(1);
      end

      default: state_d = IDLE;
    endcase

    if (grab) begin
      if (arb_any) begin
        state_d    = DRIVE;
        owner_d    = arb_idx;
        owner_oh_d = arb_pick;
        beat_d     = '0;
      end else begin
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      ptr_q      <= '0;
      beat_q     <= '0;
      turn_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      ptr_q      <= ptr_d;
      beat_q     <= beat_d;
      turn_q     <= turn_d;
      rvalid_q   <= accept;
      if (accept) rdata_q <= bus;
    end
  end

`ifdef TRI_BUS_CONTENTION_CHECK_EN
  logic contention_q;

  // Any difference, including X/Z on the wire, means another driver fought us.
  always_ff @(posedge clk) begin
    if (rst) begin
      contention_q <= 1'b0;
    end else if (accept && (bus !== owner_dat)) begin
      contention_q <= 1'b1;
    end
  end

  assign contention = contention_q;
`else
  assign contention = 1'b0;
`endif

endmodule

// File: tb/tb_tri_bus_arb.sv
// Scoreboard bench for tri_bus_arb (WIDTH=8, NCH=4, MAX_BURST=4, TURNAROUND=1).
// Stimulus pushes per-cycle expectations from a queue-level ownership model;
// a negedge monitor pops and compares against the DUT.
module tb_tri_bus_arb;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TA = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  wire  [W-1:0]   bus;
  logic [W-1:0]   rdata;
  logic           rvalid;
  logic           contention;

  always #5 clk = ~clk;

  tri_bus_arb #(.WIDTH(W), .NCH(N), .MAX_BURST(MB), .TURNAROUND(TA)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wdata      (wdata),
    .gnt        (gnt),
    .bus        (bus),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .contention (contention)
  );

`ifdef TRI_BUS_CONTENTION_CHECK_EN
  logic frc = 1'b0;
  assign bus = frc ? 8'hFF : 8'hzz;
`endif

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         acc;
    logic [W-1:0] bus;
    logic         rv;
    logic [W-1:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_chk = 0;
  int   n_err = 0;

  // Stimulus bookkeeping: beats each channel still wants to send.
  int           bl[N];
  bit           fix[N];
  logic [W-1:0] fix_dat[N];
  bit           mon_en = 1'b1;

  // Ownership model: who owns the bus, beats sent, Z cycles left, next priority.
  int           m_owner;
  int           m_burst;
  int           m_gap;
  int           m_ptr;
  logic         m_rv;
  logic [W-1:0] m_rd;

  int exp4[12] = '{0, 2, 2, 2, 2, 0, 4, 4, 4, 4, 0, 2};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_burst = 0;
    m_gap   = 0;
    m_ptr   = 0;
    m_rv    = 1'b0;
    m_rd    = '0;
  endtask

  function automatic int first_req(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_grab();
    m_owner = first_req(req, m_ptr);
    m_burst = 0;
  endtask

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input bit rs);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rs;
    for (int i = 0; i < N; i++) begin
      req[i] = (bl[i] > 0);
      wdata[i*W +: W] = fix[i] ? fix_dat[i] : W'($urandom);
    end
    e    = '0;
    e.rv = m_rv;
    e.rd = m_rd;
    if (m_owner >= 0 && req[m_owner]) begin
      e.gnt[m_owner] = 1'b1;
      e.acc = 1'b1;
      e.bus = wdata[m_owner*W +: W];
      bl[m_owner]--;
    end
    if (mon_en) sb.push_back(e);

    if (rs) begin
      model_reset();
    end else begin
      m_rv = e.acc;
      if (e.acc) m_rd = e.bus;
      if (m_owner >= 0) begin
        if (e.acc) m_burst++;
        if (!e.acc || m_burst == MB) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_gap   = TA;
          if (m_gap == 0) model_grab();
        end
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) model_grab();
      end else begin
        model_grab();
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      check("gnt", gnt, me.gnt);
      if (me.acc) check("bus", bus, me.bus);
      check("rvalid", rvalid, me.rv);
      if (me.rv) check("rdata", rdata, me.rd);
`ifndef TRI_BUS_CONTENTION_CHECK_EN
      check("contention", contention, 0);
`endif
    end
  end

  initial begin
    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) begin
      bl[i]      = 0;
      fix[i]     = 1'b0;
      fix_dat[i] = '0;
    end
    model_reset();

    // 1: reset, no requests.
    step(1);
    step(1);
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_contention", contention, 0);

    // 2: ch2 sends two beats of 8'h5A.
    fix[2] = 1'b1; fix_dat[2] = 8'h5A; bl[2] = 2;
    step(0);
    step(0); @(negedge clk);
    check("t2_gnt_b1", gnt, 4'b0100);
    check("t2_bus_b1", bus, 8'h5A);
    step(0); @(negedge clk);
    check("t2_gnt_b2", gnt, 4'b0100);
    check("t2_rvalid_b2", rvalid, 1);
    step(0); @(negedge clk);
    check("t2_gnt_drop", gnt, 0);
    check("t2_rdata", rdata, 8'h5A);
    step(0); @(negedge clk);
    check("t2_turn_rvalid", rvalid, 0);
    fix[2] = 1'b0;

    // 3: ch0 and ch3 together, one beat each, twice.
    step(1);
    bl[0] = 1; bl[3] = 1;
    step(0);
    step(0); @(negedge clk); check("t3_first_ch0", gnt, 4'b0001);
    step(0);
    step(0); @(negedge clk); check("t3_turn", gnt, 0);
    step(0); @(negedge clk); check("t3_then_ch3", gnt, 4'b1000);
    step(0);
    bl[0] = 1; bl[3] = 1;
    step(0);
    step(0); @(negedge clk); check("t3_wrap_ch0", gnt, 4'b0001);
    repeat (8) step(0);

    // 4: ch1 and ch2 held: bursts capped at four beats, alternating owners.
    bl[1] = 1000; bl[2] = 1000;
    for (int k = 0; k < 12; k++) begin
      step(0); @(negedge clk);
      check("t4_gnt_seq", gnt, exp4[k]);
    end
    bl[1] = 0; bl[2] = 0;
    repeat (4) step(0);

    // 5: reset lands on the second beat of a ch1 burst.
    step(1);
    bl[1] = 4;
    step(0);
    step(0); @(negedge clk); check("t5_b1", gnt, 4'b0010);
    bl[0] = 2;
    step(1);
    step(0); @(negedge clk);
    check("t5_post_rst_gnt", gnt, 0);
    check("t5_post_rst_rvalid", rvalid, 0);
    step(0); @(negedge clk); check("t5_ch0_wins", gnt, 4'b0001);
    repeat (20) step(0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bl[i] == 0 && $urandom_range(0, 4) == 0) bl[i] = $urandom_range(1, 6);
      end
      step($urandom_range(0, 149) == 0);
    end
    for (int i = 0; i < N; i++) bl[i] = 0;
    repeat (4) step(0);

`ifdef TRI_BUS_CONTENTION_CHECK_EN
    // 6: another driver fights a beat of 8'h00.
    @(negedge clk);
    mon_en = 1'b0;
    step(1);
    fix[0] = 1'b1; fix_dat[0] = 8'h00; bl[0] = 1;
    step(0);
    step(0);
    frc = 1'b1;
    step(0);
    frc = 1'b0;
    @(negedge clk); check("t6_contention_set", contention, 1);
    repeat (3) step(0);
    @(negedge clk); check("t6_contention_sticky", contention, 1);
    step(1);
    step(0);
    @(negedge clk); check("t6_contention_clr", contention, 0);
    fix[0] = 1'b0;
`endif

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
